cv32e40p_vec_mem_arbiter: RTL and testbench

//  Shares the single OBI-style data-memory port between the core LSU and the

---
 rtl/cv32e40p_vec_mem_arbiter.sv | 121 ++++++++++++
 tb/tb_cv32e40p_vec_mem_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_vec_mem_arbiter.sv
// Shares one OBI data port between the core LSU and the vector accelerator.
// Round-robin arbitration, hold-until-grant, and an in-order owner FIFO for response routing.
module cv32e40p_vec_mem_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [3:0]  core_be_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wdata_i,
    output logic        core_gnt_o,
    output logic        core_rvalid_o,
    output logic [31:0] core_rdata_o,
    input  logic        vec_lock_i,
    input  logic        vec_req_i,
    input  logic        vec_we_i,
    input  logic [3:0]  vec_be_i,
    input  logic [31:0] vec_addr_i,
    input  logic [31:0] vec_wdata_i,
    output logic        vec_gnt_o,
    output logic        vec_rvalid_o,
    output logic [31:0] vec_rdata_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i,
    output logic        rsp_err_o
);

    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {ARB, HOLD_CORE, HOLD_VEC} state_e;

    state_e                     state;
    logic                       rr_vec;   // 1: vec wins a tie (core was granted last)
    logic [MAX_OUTSTANDING-1:0] id_q;     // owner per slot, 1 = vec
    logic [PW-1:0]              wr_ptr, rd_ptr;
    logic [CW-1:0]              count;

    logic core_cand, arb_vec, sel_vec, req_raw;
    logic fifo_empty, fifo_full, push, pop, head_vec;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign core_cand  = core_req_i & ~vec_lock_i;
    assign arb_vec    = vec_req_i & (~core_cand | rr_vec);
    assign fifo_empty = (count == '0);
    // A response popping this cycle frees a slot for a new grant in the same cycle.
    assign fifo_full  = (count == CW'(MAX_OUTSTANDING)) & ~data_rvalid_i;
    assign pop        = data_rvalid_i & ~fifo_empty;
    assign head_vec   = id_q[rd_ptr];

    always_comb begin
        sel_vec = 1'b0;
        req_raw = 1'b0;
        case (state)
            ARB: begin
                sel_vec = arb_vec;
                req_raw = (core_cand | vec_req_i) & ~fifo_full;
            end
            HOLD_CORE: req_raw = 1'b1;
            HOLD_VEC: begin
                sel_vec = 1'b1;
                req_raw = 1'b1;
            end
            default: ;
        endcase
    end

    assign data_req_o   = rst_ni & req_raw;
    assign push         = data_req_o & data_gnt_i;
    assign core_gnt_o   = push & ~sel_vec;
    assign vec_gnt_o    = push & sel_vec;
    assign data_we_o    = data_req_o & (sel_vec ? vec_we_i : core_we_i);
    assign data_be_o    = data_req_o ? (sel_vec ? vec_be_i : core_be_i) : '0;
    assign data_addr_o  = data_req_o ? (sel_vec ? vec_addr_i : core_addr_i) : '0;
    assign data_wdata_o = data_req_o ? (sel_vec ? vec_wdata_i : core_wdata_i) : '0;

    assign core_rvalid_o = rst_ni & pop & ~head_vec;
    assign vec_rvalid_o  = rst_ni & pop & head_vec;
    assign core_rdata_o  = core_rvalid_o ? data_rdata_i : '0;
    assign vec_rdata_o   = vec_rvalid_o ? data_rdata_i : '0;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state     <= ARB;
            rr_vec    <= 1'b0;
            id_q      <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rsp_err_o <= 1'b0;
        end else begin
            if (push) begin
                id_q[wr_ptr] <= sel_vec;
                wr_ptr       <= ptr_inc(wr_ptr);
                rr_vec       <= ~sel_vec;
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (data_rvalid_i && fifo_empty) rsp_err_o <= 1'b1;
            case (state)
                ARB:       if (data_req_o && !data_gnt_i) state <= sel_vec ? HOLD_VEC : HOLD_CORE;
                HOLD_CORE: if (data_gnt_i) state <= ARB;
                HOLD_VEC:  if (data_gnt_i) state <= ARB;
                default:   state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_cv32e40p_vec_mem_arbiter.sv
// Self-checking bench for cv32e40p_vec_mem_arbiter: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_cv32e40p_vec_mem_arbiter;

    localparam int MAXO = 2;

    logic        clk = 0;
    logic        rst_ni;
    logic        core_req, core_we, vec_lock, vec_req, vec_we;
    logic [3:0]  core_be, vec_be;
    logic [31:0] core_addr, core_wdata, vec_addr, vec_wdata;
    logic        core_gnt, core_rvalid, vec_gnt, vec_rvalid;
    logic [31:0] core_rdata, vec_rdata;
    logic        data_req, data_gnt, data_rvalid, data_we, rsp_err;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata, data_rdata;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cv32e40p_vec_mem_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .core_req_i(core_req), .core_we_i(core_we), .core_be_i(core_be),
        .core_addr_i(core_addr), .core_wdata_i(core_wdata),
        .core_gnt_o(core_gnt), .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata),
        .vec_lock_i(vec_lock), .vec_req_i(vec_req), .vec_we_i(vec_we), .vec_be_i(vec_be),
        .vec_addr_i(vec_addr), .vec_wdata_i(vec_wdata),
        .vec_gnt_o(vec_gnt), .vec_rvalid_o(vec_rvalid), .vec_rdata_o(vec_rdata),
        .data_req_o(data_req), .data_gnt_i(data_gnt), .data_rvalid_i(data_rvalid),
        .data_we_o(data_we), .data_be_o(data_be), .data_addr_o(data_addr),
        .data_wdata_o(data_wdata), .data_rdata_i(data_rdata), .rsp_err_o(rsp_err)
    );

    task automatic clear_inputs();
        core_req = 0; core_we = 0; core_be = 0; core_addr = 0; core_wdata = 0;
        vec_lock = 0; vec_req = 0; vec_we = 0; vec_be = 0; vec_addr = 0; vec_wdata = 0;
        data_gnt = 0; data_rvalid = 0; data_rdata = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst_ni = 0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst_ni = 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_ni = 0;
        core_req = 1; vec_req = 1; core_addr = 32'h55; data_gnt = 1; data_rvalid = 1;
        data_rdata = 32'hFFFF_FFFF;
        @(posedge clk); @(negedge clk); #1;
        n_chk++;
        if ({data_req, core_gnt, vec_gnt, core_rvalid, vec_rvalid, rsp_err} !== 6'b0
            || data_addr !== 0 || core_rdata !== 0 || vec_rdata !== 0) begin
            n_fail++;
            $display("FAIL reset_outputs: req=%b gnt=%b%b rv=%b%b err=%b addr=%h, required all 0",
                     data_req, core_gnt, vec_gnt, core_rvalid, vec_rvalid, rsp_err, data_addr);
        end
        do_reset();
    endtask

    task automatic test_core_read();
        do_reset();
        core_req = 1; core_addr = 32'h100; core_be = 4'hF; data_gnt = 1;
        #1;
        n_chk++;
        if ({data_req, core_gnt, vec_gnt} !== 3'b110 || data_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL core_read_gnt: req/cg/vg=%b addr=%h, required 110 addr 00000100",
                     {data_req, core_gnt, vec_gnt}, data_addr);
        end
        @(negedge clk);
        core_req = 0; data_gnt = 0; data_rvalid = 1; data_rdata = 32'hDEADBEEF;
        #1;
        n_chk++;
        if ({core_rvalid, vec_rvalid, core_gnt} !== 3'b100 || core_rdata !== 32'hDEADBEEF
            || vec_rdata !== 0) begin
            n_fail++;
            $display("FAIL core_read_rsp: rv c/v=%b%b crd=%h vrd=%h, required 10 deadbeef 0",
                     core_rvalid, vec_rvalid, core_rdata, vec_rdata);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_alternate();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            core_req = (i < 4); vec_req = (i < 4); core_addr = 32'hC0 + i; vec_addr = 32'hE0 + i;
            data_gnt = (i < 4); data_rvalid = (i > 0); data_rdata = 32'hA000 + i;
            #1;
            if (i < 4) begin
                n_chk++;
                if ({core_gnt, vec_gnt} !== ((i % 2) ? 2'b01 : 2'b10)) begin
                    n_fail++;
                    $display("FAIL alt_gnt[%0d]: cg/vg=%b, required %b", i, {core_gnt, vec_gnt},
                             (i % 2) ? 2'b01 : 2'b10);
                end
            end
            if (i > 0) begin
                n_chk++;
                if ({core_rvalid, vec_rvalid} !== (((i - 1) % 2) ? 2'b01 : 2'b10)
                    || (core_rdata | vec_rdata) !== 32'hA000 + i) begin
                    n_fail++;
                    $display("FAIL alt_rsp[%0d]: rv c/v=%b rdata=%h", i, {core_rvalid, vec_rvalid},
                             core_rdata | vec_rdata);
                end
            end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    task automatic test_hold();
        do_reset();
        core_req = 1; core_addr = 32'h300; vec_addr = 32'h400;
        for (int i = 0; i < 3; i++) begin
            vec_req = (i > 0);
            #1;
            n_chk++;
            if (data_addr !== 32'h300 || {data_req, core_gnt, vec_gnt} !== 3'b100) begin
                n_fail++;
                $display("FAIL hold_core[%0d]: addr=%h req/cg/vg=%b, required 00000300 100",
                         i, data_addr, {data_req, core_gnt, vec_gnt});
            end
            @(negedge clk);
        end
        data_gnt = 1;
        #1;
        n_chk++;
        if (data_addr !== 32'h300 || {core_gnt, vec_gnt} !== 2'b10) begin
            n_fail++;
            $display("FAIL hold_core_gnt: addr=%h cg/vg=%b, required 00000300 10",
                     data_addr, {core_gnt, vec_gnt});
        end
        @(negedge clk);
        core_req = 0; data_rvalid = 1;
        #1;
        n_chk++;
        if (data_addr !== 32'h400 || {core_gnt, vec_gnt} !== 2'b01) begin
            n_fail++;
            $display("FAIL hold_vec_after: addr=%h cg/vg=%b, required 00000400 01",
                     data_addr, {core_gnt, vec_gnt});
        end
        @(negedge clk);
        clear_inputs(); data_rvalid = 1;
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_full();
        do_reset();
        core_req = 1; data_gnt = 1;
        for (int i = 0; i < 2; i++) begin
            core_addr = 32'h500 + 4 * i;
            #1;
            n_chk++;
            if (core_gnt !== 1'b1) begin
                n_fail++;
                $display("FAIL full_fill[%0d]: core_gnt=%b, required 1", i, core_gnt);
            end
            @(negedge clk);
        end
        core_addr = 32'h508;
        #1;
        n_chk++;
        if ({data_req, core_gnt} !== 2'b00 || data_addr !== 0) begin
            n_fail++;
            $display("FAIL full_block: req/cg=%b addr=%h, required 00 0", {data_req, core_gnt}, data_addr);
        end
        @(negedge clk);
        data_rvalid = 1; data_rdata = 32'h1234;
        #1;
        n_chk++;
        if ({data_req, core_gnt, core_rvalid} !== 3'b111 || core_rdata !== 32'h1234) begin
            n_fail++;
            $display("FAIL full_push_pop: req/cg/crv=%b rdata=%h, required 111 1234",
                     {data_req, core_gnt, core_rvalid}, core_rdata);
        end
        @(negedge clk);
        data_rvalid = 0; core_addr = 32'h50C;
        #1;
        n_chk++;
        if (data_req !== 1'b0) begin
            n_fail++;
            $display("FAIL full_still: data_req=%b, required 0 (count stays 2)", data_req);
        end
        @(negedge clk);
        core_req = 0; data_gnt = 0;
        for (int i = 0; i < 2; i++) begin
            data_rvalid = 1; #1;
            n_chk++;
            if (core_rvalid !== 1'b1) begin
                n_fail++;
                $display("FAIL full_drain[%0d]: core_rvalid=%b, required 1", i, core_rvalid);
            end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    task automatic test_lock();
        do_reset();
        core_req = 1; core_addr = 32'h200; data_gnt = 1;
        #1;
        n_chk++;
        if (core_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_pre: core_gnt=%b, required 1", core_gnt);
        end
        @(negedge clk);
        vec_lock = 1; vec_req = 1; vec_addr = 32'h600;
        for (int i = 1; i <= 5; i++) begin
            data_rvalid = 1; data_rdata = 32'h1000 + i;
            #1;
            n_chk++;
            if ({core_gnt, vec_gnt} !== 2'b01 || data_addr !== 32'h600) begin
                n_fail++;
                $display("FAIL lock_gnt[%0d]: cg/vg=%b addr=%h, required 01 00000600",
                         i, {core_gnt, vec_gnt}, data_addr);
            end
            n_chk++;
            if ({core_rvalid, vec_rvalid} !== ((i == 1) ? 2'b10 : 2'b01)
                || (core_rdata | vec_rdata) !== 32'h1000 + i) begin
                n_fail++;
                $display("FAIL lock_rsp[%0d]: rv c/v=%b rdata=%h", i, {core_rvalid, vec_rvalid},
                         core_rdata | vec_rdata);
            end
            @(negedge clk);
        end
        clear_inputs(); data_rvalid = 1;
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_err();
        do_reset();
        data_rvalid = 1; data_rdata = 32'h77;
        #1;
        n_chk++;
        if ({core_rvalid, vec_rvalid} !== 2'b00) begin
            n_fail++;
            $display("FAIL err_no_rvalid: rv c/v=%b, required 00", {core_rvalid, vec_rvalid});
        end
        @(negedge clk);
        data_rvalid = 0;
        repeat (3) @(negedge clk);
        #1;
        n_chk++;
        if (rsp_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: rsp_err=%b, required 1", rsp_err);
        end
        do_reset();
        #1;
        n_chk++;
        if (rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_cleared: rsp_err=%b, required 0", rsp_err);
        end
    endtask

    // Reference model: a queue of owners, an optional held side, and the last-granted side.
    task automatic test_random();
        int q[$];
        int held = -1;
        int last = 1;
        bit drop_c = 0, drop_v = 0;
        bit ereq, eside, cc, vc;
        logic [71:0] got, exp;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (drop_c) core_req = 0;
            if (drop_v) vec_req = 0;
            drop_c = 0; drop_v = 0;
            if (!core_req && $urandom_range(0, 2) == 0) begin
                core_req = 1; core_addr = $urandom; core_wdata = $urandom;
                core_we = 1'($urandom); core_be = 4'($urandom);
            end
            if (!vec_req && $urandom_range(0, 2) == 0) begin
                vec_req = 1; vec_addr = $urandom; vec_wdata = $urandom;
                vec_we = 1'($urandom); vec_be = 4'($urandom);
            end
            if ($urandom_range(0, 15) == 0) vec_lock = ~vec_lock;
            data_gnt = 1'($urandom);
            data_rvalid = (q.size() > 0) && ($urandom_range(0, 2) == 0);
            data_rdata = $urandom;
            cc = core_req && !vec_lock;
            vc = vec_req;
            if (held >= 0) begin
                ereq = 1; eside = 1'(held);
            end else begin
                ereq = (cc || vc) && (q.size() < MAXO || data_rvalid);
                eside = (cc && vc) ? (last == 0) : vc;
            end
            #1;
            exp = '0;
            exp[71] = ereq;
            exp[70] = ereq && data_gnt && !eside;
            exp[69] = ereq && data_gnt && eside;
            if (ereq) begin
                exp[68:37] = eside ? vec_addr : core_addr;
                exp[36]    = eside ? vec_we : core_we;
            end
            if (data_rvalid) begin
                exp[35] = (q[0] == 0);
                exp[34] = (q[0] == 1);
                exp[33:2] = data_rdata;
            end
            got = {data_req, core_gnt, vec_gnt, data_addr, data_we, core_rvalid, vec_rvalid,
                   core_rdata | vec_rdata, rsp_err, core_gnt & vec_gnt};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h required %h", cyc, got, exp);
            end
            n_chk++;
            if (ereq && (data_wdata !== (eside ? vec_wdata : core_wdata)
                         || data_be !== (eside ? vec_be : core_be))) begin
                n_fail++;
                $display("FAIL random_wdata[%0d]: wdata=%h be=%h", cyc, data_wdata, data_be);
            end
            if (data_rvalid) void'(q.pop_front());
            if (ereq && data_gnt) begin
                q.push_back(int'(eside));
                last = int'(eside);
                held = -1;
                if (eside) drop_v = 1; else drop_c = 1;
            end else if (ereq) begin
                held = int'(eside);
            end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    initial begin
        rst_ni = 0;
        clear_inputs();
        test_reset();
        test_core_read();
        test_alternate();
        test_hold();
        test_full();
        test_lock();
        test_err();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
